// File: rtl/matrix_3x3_gen_if.sv
// Stream bundle between a raster pixel source and the 3x3 window generator.
// The master drives pixels; the slave returns the nine-pixel window and strobes.
interface matrix_3x3_gen_if;
  logic [7:0] pix_data;
  logic       pix_en;
  logic       frame_start;
  logic [7:0] matrix_p11, matrix_p12, matrix_p13;
  logic [7:0] matrix_p21, matrix_p22, matrix_p23;
  logic [7:0] matrix_p31, matrix_p32, matrix_p33;
  logic       matrix_en;
  logic       frame_end;

  modport master (
    output pix_data, pix_en, frame_start,
    input  matrix_p11, matrix_p12, matrix_p13,
    input  matrix_p21, matrix_p22, matrix_p23,
    input  matrix_p31, matrix_p32, matrix_p33,
    input  matrix_en, frame_end
  );

  modport slave (
    input  pix_data, pix_en, frame_start,
    output matrix_p11, matrix_p12, matrix_p13,
    output matrix_p21, matrix_p22, matrix_p23,
    output matrix_p31, matrix_p32, matrix_p33,
    output matrix_en, frame_end
  );
endinterface

// File: rtl/matrix_3x3_gen.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a 3x3 shift
// window, emitting a strobe only for windows lying fully inside the image.
module matrix_3x3_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic              clk,
  input  logic              rst_n,
  matrix_3x3_gen_if.slave   bus
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0] col, cur_col;
  logic [RW-1:0] row, cur_row;
  logic [7:0]    lb0 [IMG_WIDTH];
  logic [7:0]    lb1 [IMG_WIDTH];
  logic [7:0]    lb0_rd, lb1_rd;
  logic [7:0]    win [3][3];
  logic          matrix_en_q, frame_end_q;

  // frame_start forces the pixel arriving with it to be treated as (0,0).
  always_comb begin
    cur_col = col;
    cur_row = row;
    if (bus.frame_start) begin
      cur_col = '0;
      cur_row = '0;
    end
  end

  assign lb0_rd = lb0[cur_col];
  assign lb1_rd = lb1[cur_col];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (bus.pix_en) begin
      if (cur_col == COL_LAST) begin
        col <= '0;
        row <= (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
      end else begin
        col <= cur_col + CW'(1);
        row <= cur_row;
      end
    end else if (bus.frame_start) begin
      col <= '0;
      row <= '0;
    end
  end

  // NOTE: line buffers carry no reset so they map onto plain RAM; rows 0 and 1
  // of each frame never produce a strobe, so stale content is never observed.
  always_ff @(posedge clk) begin
    if (bus.pix_en) begin
      lb0[cur_col] <= lb1_rd;
      lb1[cur_col] <= bus.pix_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= '0;
      matrix_en_q <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      matrix_en_q <= bus.pix_en && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
      frame_end_q <= bus.pix_en && (cur_row == ROW_LAST) && (cur_col == COL_LAST);
      if (bus.pix_en) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= lb0_rd;
        win[1][2] <= lb1_rd;
        win[2][2] <= bus.pix_data;
      end
    end
  end

  assign bus.matrix_p11 = win[0][0];
  assign bus.matrix_p12 = win[0][1];
  assign bus.matrix_p13 = win[0][2];
  assign bus.matrix_p21 = win[1][0];
  assign bus.matrix_p22 = win[1][1];
  assign bus.matrix_p23 = win[1][2];
  assign bus.matrix_p31 = win[2][0];
  assign bus.matrix_p32 = win[2][1];
  assign bus.matrix_p33 = win[2][2];
  assign bus.matrix_en  = matrix_en_q;
  assign bus.frame_end  = frame_end_q;

endmodule

// File: doc/matrix_3x3_gen.md
# matrix_3x3_gen

Streaming 3x3 neighbourhood generator that converts a raster pixel stream into the nine-pixel window `matrix_p11`..`matrix_p33` plus a qualifying enable. It is the producer feeding the Sobel and mean filter stages in the VGA picture-display pipeline. It holds the two previous image lines in on-chip line buffers and a 3x3 shift window. Only windows lying entirely inside the image are emitted.

## Interface
Parameters:
- `IMG_WIDTH`, default 640: active pixels per line; must be ≥ 3.
- `IMG_HEIGHT`, default 480: active lines per frame; must be ≥ 3.

Ports:
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `pix_data`  input  8  grey pixel; sampled only when `pix_en`=1.
- `pix_en`  input  1  pixel valid strobe; any duty cycle, gaps allowed.
- `frame_start`  input  1  synchronous pulse that re-aligns counters to pixel (0,0).
- `matrix_p11`, `matrix_p12`, `matrix_p13`  output  8 each  window row r-2, columns c-2, c-1, c.
- `matrix_p21`, `matrix_p22`, `matrix_p23`  output  8 each  window row r-1, columns c-2, c-1, c.
- `matrix_p31`, `matrix_p32`, `matrix_p33`  output  8 each  window row r, columns c-2, c-1, c (`p33` = newest pixel).
- `matrix_en`  output  1  one-cycle strobe: the window is valid and centred on (r-1, c-1).
- `frame_end`  output  1  one-cycle strobe on acceptance of pixel (IMG_HEIGHT-1, IMG_WIDTH-1).

## Operation
- Counters:
  - `col` has `$clog2(IMG_WIDTH)` bits; `row` has `$clog2(IMG_HEIGHT)` bits.
  - Both advance only on `pix_en`.
  - `col` wraps IMG_WIDTH-1→0 and increments `row`.
  - `row` wraps IMG_HEIGHT-1→0, which starts the next frame automatically.
- Line buffers: two arrays `lb0` (row r-2) and `lb1` (row r-1), each IMG_WIDTH×8, indexed by `col`, with combinational read.
- On `pix_en` at column c:
  - Read `lb0[c]` and `lb1[c]`.
  - Write `lb0[c]` ← old `lb1[c]` and `lb1[c]` ← `pix_data`.
  - Shift the window left one column: column 3 becomes {`lb0[c]`, `lb1[c]`, `pix_data`}.
- Window columns are not cleared at line start. Stale columns from the previous line are present when c<2, but those windows are suppressed.
- `matrix_en` is 1 exactly when the accepted pixel has `row` ≥ 2 and `col` ≥ 2. This gives (IMG_HEIGHT-2)×(IMG_WIDTH-2) strobes per frame.
- `frame_start`:
  - With `pix_en` low, it sets `row`=`col`=0.
  - Coinciding with `pix_en`, the accompanying pixel is taken as (0,0); counters then become row 0, col 1.
  - Line-buffer contents are not cleared; the r<2 suppression makes their content irrelevant.
- A `frame_start` mid-frame abandons the current frame. No `frame_end` is issued for the abandoned frame.
- No backpressure: every `pix_en` pixel is consumed.

## Timing
- Reset values:
  - All `matrix_p*` = 0.
  - `matrix_en` = 0 and `frame_end` = 0.
  - `row` = `col` = 0.
  - Window registers = 0.
  - Line buffers are not reset.
- Latency:
  - A pixel accepted at edge N appears on `matrix_p33` after edge N, i.e. in cycle N+1.
  - `matrix_en` and `frame_end` are high for that same single cycle.
- With `pix_en` low:
  - `matrix_en` and `frame_end` are 0.
  - `matrix_p*` hold their last values.
- Throughput: one pixel per clock sustained. Gaps in `pix_en` stall the window without data loss.
- Reset asserted mid-frame clears outputs immediately (asynchronous). The first pixel after release is (0,0).

## Test plan
- Reset check: hold `rst_n`=0 with random inputs → all outputs are 0; after release with no `pix_en`, outputs stay 0.
- Ramp image, IMG_WIDTH=4, IMG_HEIGHT=4, pixel=4r+c, continuous `pix_en`:
  - Exactly 4 `matrix_en` strobes.
  - First strobe: p11..p33 = 0,1,2 / 4,5,6 / 8,9,10.
  - Last strobe: 5,6,7 / 9,10,11 / 13,14,15.
  - `frame_end` coincides with the last strobe.
- Same ramp with `pix_en` toggling 1,0,0,1… → identical window sequence; `matrix_p*` stable across the gaps.
- Two back-to-back frames without `frame_start`, frame-2 pixel = 100+4r+c → frame-2 first window is 100,101,102 / 104,105,106 / 108,109,110, with no contamination from frame 1.
- `frame_start` coincident with `pix_en` after 7 pixels of frame 1 → that pixel is treated as (0,0); a full 4x4 ramp then yields exactly 4 correct strobes, and the abandoned frame produces no `frame_end`.
- Asynchronous reset at row 2, col 3 (between edges) → outputs clear immediately; a fresh 4x4 frame then produces the correct 4 windows.
